// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port memory between the core fetch
// port and the loader/debug port. Arbitration is round-robin. A RUN/LOAD mode FSM holds the core.
module imem_arbiter #(
   parameter int MEM_ADDR_WIDTH = 12,
   parameter bit BOOT_IN_LOAD   = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_gnt,
   output logic        o_if_rvalid,
   output logic [31:0] o_if_rdata,
   input  logic        i_ld_req,
   input  logic        i_ld_we,
   input  logic [31:0] i_ld_addr,
   input  logic [31:0] i_ld_wdata,
   input  logic [3:0]  i_ld_size,
   output logic        o_ld_gnt,
   output logic        o_ld_rvalid,
   output logic [31:0] o_ld_rdata,
   output logic        o_ld_err,
   input  logic        i_ld_start,
   input  logic        i_ld_done,
   output logic        o_cpu_hold,
   output logic [15:0] o_ld_wr_count,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wr_data,
   output logic [3:0]  o_mem_size,
   output logic        o_mem_write,
   output logic        o_mem_read,
   input  logic [31:0] i_mem_rd_data
);

   // state | meaning
   // RUN   | core runs; fetch and loader share the memory round-robin
   // LOAD  | core held; only the loader may access the memory
   typedef enum logic {ST_RUN = 1'b0, ST_LOAD = 1'b1} mode_e;

   localparam logic [31:0] HI_MASK = ~((32'd1 << MEM_ADDR_WIDTH) - 32'd1);
   localparam mode_e       RST_MODE = BOOT_IN_LOAD ? ST_LOAD : ST_RUN;

   mode_e       state_q, state_d;
   logic        last_ld_q, last_ld_d;
   logic        if_rvalid_q, if_rvalid_d;
   logic        ld_rvalid_q, ld_rvalid_d;
   logic [31:0] if_rdata_q, ld_rdata_q;
   logic        ld_err_q, ld_err_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;

   logic        if_elig, ld_elig;
   logic        gnt_if, gnt_ld;
   logic        ld_oor;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= RST_MODE;
         last_ld_q   <= 1'b1;
         if_rvalid_q <= 1'b0;
         ld_rvalid_q <= 1'b0;
         if_rdata_q  <= 32'h0;
         ld_rdata_q  <= 32'h0;
         ld_err_q    <= 1'b0;
         wr_cnt_q    <= 16'h0;
      end else begin
         state_q     <= state_d;
         last_ld_q   <= last_ld_d;
         if_rvalid_q <= if_rvalid_d;
         ld_rvalid_q <= ld_rvalid_d;
         ld_err_q    <= ld_err_d;
         wr_cnt_q    <= wr_cnt_d;
         if (if_rvalid_q) if_rdata_q <= i_mem_rd_data;
         if (ld_rvalid_q) ld_rdata_q <= i_mem_rd_data;
      end
   end

   always_comb begin
      state_d       = state_q;
      last_ld_d     = last_ld_q;
      if_rvalid_d   = 1'b0;
      ld_rvalid_d   = 1'b0;
      ld_err_d      = 1'b0;
      wr_cnt_d      = wr_cnt_q;
      o_mem_addr    = 32'h0;
      o_mem_wr_data = 32'h0;
      o_mem_size    = 4'h0;
      o_mem_write   = 1'b0;
      o_mem_read    = 1'b0;

      // Grants are suppressed while reset is asserted so the memory bus is idle.
      if_elig = !i_rst && (state_q == ST_RUN) && i_if_req;
      ld_elig = !i_rst && i_ld_req;
      gnt_if  = if_elig && (!ld_elig || last_ld_q);
      gnt_ld  = ld_elig && (!if_elig || !last_ld_q);
      ld_oor  = |(i_ld_addr & HI_MASK);

      if (gnt_ld)      last_ld_d = 1'b1;
      else if (gnt_if) last_ld_d = 1'b0;

      if (i_ld_done)       state_d = ST_RUN;
      else if (i_ld_start) state_d = ST_LOAD;

      if (gnt_if) begin
         o_mem_addr  = i_if_addr;
         o_mem_read  = 1'b1;
         o_mem_size  = 4'hF;
         if_rvalid_d = 1'b1;
      end else if (gnt_ld) begin
         o_mem_addr = i_ld_addr;
         if (!i_ld_we) begin
            o_mem_read  = 1'b1;
            o_mem_size  = 4'hF;
            ld_rvalid_d = 1'b1;
         end else if (ld_oor) begin
            ld_err_d = 1'b1;
         end else begin
            o_mem_write   = 1'b1;
            o_mem_size    = i_ld_size;
            o_mem_wr_data = i_ld_wdata;
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
         end
      end

      // Entering LOAD starts a fresh count, even if a write lands in the same cycle.
      if (state_q == ST_RUN && state_d == ST_LOAD) wr_cnt_d = 16'h0;
   end

   assign o_if_gnt      = gnt_if;
   assign o_ld_gnt      = gnt_ld;
   assign o_if_rvalid   = if_rvalid_q;
   assign o_ld_rvalid   = ld_rvalid_q;
   assign o_if_rdata    = if_rvalid_q ? i_mem_rd_data : if_rdata_q;
   assign o_ld_rdata    = ld_rvalid_q ? i_mem_rd_data : ld_rdata_q;
   assign o_ld_err      = ld_err_q;
   assign o_ld_wr_count = wr_cnt_q;
   assign o_cpu_hold    = (state_q == ST_LOAD);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: one RUN-boot instance exercised in depth, plus a
// LOAD-boot instance that is checked for its reset mode.
module tb_imem_arbiter;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_if_req, i_ld_req, i_ld_we, i_ld_start, i_ld_done;
   logic [31:0] i_if_addr, i_ld_addr, i_ld_wdata, i_mem_rd_data;
   logic [3:0]  i_ld_size;

   logic        o_if_gnt, o_if_rvalid, o_ld_gnt, o_ld_rvalid, o_ld_err, o_cpu_hold;
   logic        o_mem_write, o_mem_read;
   logic [31:0] o_if_rdata, o_ld_rdata, o_mem_addr, o_mem_wr_data;
   logic [15:0] o_ld_wr_count;
   logic [3:0]  o_mem_size;

   logic        b_if_gnt, b_if_rvalid, b_ld_gnt, b_ld_rvalid, b_ld_err, b_cpu_hold;
   logic        b_mem_write, b_mem_read;
   logic [31:0] b_if_rdata, b_ld_rdata, b_mem_addr, b_mem_wr_data;
   logic [15:0] b_ld_wr_count;
   logic [3:0]  b_mem_size;

   int errors = 0;
   int checks = 0;

   initial forever #5 i_clk = ~i_clk;

   imem_arbiter #(.MEM_ADDR_WIDTH(12), .BOOT_IN_LOAD(1'b0)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
      .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
      .i_ld_req(i_ld_req), .i_ld_we(i_ld_we), .i_ld_addr(i_ld_addr),
      .i_ld_wdata(i_ld_wdata), .i_ld_size(i_ld_size), .o_ld_gnt(o_ld_gnt),
      .o_ld_rvalid(o_ld_rvalid), .o_ld_rdata(o_ld_rdata), .o_ld_err(o_ld_err),
      .i_ld_start(i_ld_start), .i_ld_done(i_ld_done), .o_cpu_hold(o_cpu_hold),
      .o_ld_wr_count(o_ld_wr_count), .o_mem_addr(o_mem_addr),
      .o_mem_wr_data(o_mem_wr_data), .o_mem_size(o_mem_size),
      .o_mem_write(o_mem_write), .o_mem_read(o_mem_read),
      .i_mem_rd_data(i_mem_rd_data)
   );

   imem_arbiter #(.MEM_ADDR_WIDTH(12), .BOOT_IN_LOAD(1'b1)) dut_boot (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(b_if_gnt),
      .o_if_rvalid(b_if_rvalid), .o_if_rdata(b_if_rdata),
      .i_ld_req(i_ld_req), .i_ld_we(i_ld_we), .i_ld_addr(i_ld_addr),
      .i_ld_wdata(i_ld_wdata), .i_ld_size(i_ld_size), .o_ld_gnt(b_ld_gnt),
      .o_ld_rvalid(b_ld_rvalid), .o_ld_rdata(b_ld_rdata), .o_ld_err(b_ld_err),
      .i_ld_start(i_ld_start), .i_ld_done(i_ld_done), .o_cpu_hold(b_cpu_hold),
      .o_ld_wr_count(b_ld_wr_count), .o_mem_addr(b_mem_addr),
      .o_mem_wr_data(b_mem_wr_data), .o_mem_size(b_mem_size),
      .o_mem_write(b_mem_write), .o_mem_read(b_mem_read),
      .i_mem_rd_data(i_mem_rd_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1;
      i_if_req = 0; i_ld_req = 0; i_ld_we = 0; i_ld_start = 0; i_ld_done = 0;
      i_if_addr = 0; i_ld_addr = 0; i_ld_wdata = 0; i_mem_rd_data = 0; i_ld_size = 0;
      #2;
      chk("rst_if_rvalid", {31'b0, o_if_rvalid}, 32'd0);
      chk("rst_ld_rvalid", {31'b0, o_ld_rvalid}, 32'd0);
      chk("rst_if_rdata", o_if_rdata, 32'd0);
      chk("rst_ld_err", {31'b0, o_ld_err}, 32'd0);
      chk("rst_wr_count", {16'b0, o_ld_wr_count}, 32'd0);
      chk("rst_cpu_hold", {31'b0, o_cpu_hold}, 32'd0);
      chk("rst_boot_hold", {31'b0, b_cpu_hold}, 32'd1);
      step();
      i_rst = 1'b0;

      // Fetch only: three reads of 0x10
      i_if_req = 1; i_if_addr = 32'h10; #1;
      chk("f1_gnt", {31'b0, o_if_gnt}, 32'd1);
      chk("f1_read", {31'b0, o_mem_read}, 32'd1);
      chk("f1_addr", o_mem_addr, 32'h10);
      chk("f1_size", {28'b0, o_mem_size}, 32'hF);
      chk("f1_rvalid", {31'b0, o_if_rvalid}, 32'd0);
      chk("boot_no_fetch", {31'b0, b_if_gnt}, 32'd0);
      step(); i_mem_rd_data = 32'h1111_1111; #1;
      chk("f2_gnt", {31'b0, o_if_gnt}, 32'd1);
      chk("f2_rvalid", {31'b0, o_if_rvalid}, 32'd1);
      chk("f2_rdata", o_if_rdata, 32'h1111_1111);
      chk("f2_ld_rvalid", {31'b0, o_ld_rvalid}, 32'd0);
      step(); i_mem_rd_data = 32'h2222_2222; #1;
      chk("f3_rdata", o_if_rdata, 32'h2222_2222);
      step(); i_if_req = 0; i_mem_rd_data = 32'h3333_3333; #1;
      chk("f4_gnt", {31'b0, o_if_gnt}, 32'd0);
      chk("f4_rvalid", {31'b0, o_if_rvalid}, 32'd1);
      chk("f4_rdata", o_if_rdata, 32'h3333_3333);
      chk("idle_addr", o_mem_addr, 32'd0);
      chk("idle_read", {31'b0, o_mem_read}, 32'd0);
      step(); i_mem_rd_data = 32'hDEAD_BEEF; #1;
      chk("f5_rvalid", {31'b0, o_if_rvalid}, 32'd0);
      chk("f5_hold_rdata", o_if_rdata, 32'h3333_3333);

      // Contention from reset: F, L, F, L
      do_reset();
      i_if_req = 1; i_if_addr = 32'h10;
      i_ld_req = 1; i_ld_we = 0; i_ld_addr = 32'h20; #1;
      chk("c1_if_gnt", {31'b0, o_if_gnt}, 32'd1);
      chk("c1_ld_gnt", {31'b0, o_ld_gnt}, 32'd0);
      chk("c1_addr", o_mem_addr, 32'h10);
      step(); i_mem_rd_data = 32'hA1; #1;
      chk("c2_ld_gnt", {31'b0, o_ld_gnt}, 32'd1);
      chk("c2_if_gnt", {31'b0, o_if_gnt}, 32'd0);
      chk("c2_addr", o_mem_addr, 32'h20);
      chk("c2_if_rvalid", {31'b0, o_if_rvalid}, 32'd1);
      chk("c2_ld_rvalid", {31'b0, o_ld_rvalid}, 32'd0);
      chk("c2_if_rdata", o_if_rdata, 32'hA1);
      step(); i_mem_rd_data = 32'hA2; #1;
      chk("c3_if_gnt", {31'b0, o_if_gnt}, 32'd1);
      chk("c3_ld_rvalid", {31'b0, o_ld_rvalid}, 32'd1);
      chk("c3_if_rvalid", {31'b0, o_if_rvalid}, 32'd0);
      chk("c3_ld_rdata", o_ld_rdata, 32'hA2);
      chk("c3_if_rdata_hold", o_if_rdata, 32'hA1);
      step(); i_mem_rd_data = 32'hA3; #1;
      chk("c4_ld_gnt", {31'b0, o_ld_gnt}, 32'd1);
      chk("c4_if_rdata", o_if_rdata, 32'hA3);
      step(); i_ld_req = 0; i_mem_rd_data = 32'hA4; #1;
      chk("c5_ld_rdata", o_ld_rdata, 32'hA4);
      chk("c5_if_rvalid", {31'b0, o_if_rvalid}, 32'd0);

      // Start LOAD while a fetch is granted; that read must still return
      i_ld_start = 1; #1;
      chk("s_if_gnt", {31'b0, o_if_gnt}, 32'd1);
      step(); i_ld_start = 0; i_mem_rd_data = 32'hB0;
      i_ld_req = 1; i_ld_we = 1; i_ld_addr = 32'h0; i_ld_wdata = 32'hCAFE_0000; i_ld_size = 4'hF; #1;
      chk("s_if_rvalid", {31'b0, o_if_rvalid}, 32'd1);
      chk("s_if_rdata", o_if_rdata, 32'hB0);
      chk("l_hold", {31'b0, o_cpu_hold}, 32'd1);
      chk("l_if_blocked", {31'b0, o_if_gnt}, 32'd0);
      chk("w0_gnt", {31'b0, o_ld_gnt}, 32'd1);
      chk("w0_write", {31'b0, o_mem_write}, 32'd1);
      chk("w0_read", {31'b0, o_mem_read}, 32'd0);
      chk("w0_data", o_mem_wr_data, 32'hCAFE_0000);
      chk("w0_size", {28'b0, o_mem_size}, 32'hF);
      chk("w0_cnt", {16'b0, o_ld_wr_count}, 32'd0);
      step(); i_ld_addr = 32'h4; i_ld_wdata = 32'hCAFE_0004; #1;
      chk("w1_write", {31'b0, o_mem_write}, 32'd1);
      chk("w1_addr", o_mem_addr, 32'h4);
      chk("w1_cnt", {16'b0, o_ld_wr_count}, 32'd1);
      chk("w1_no_rvalid", {31'b0, o_ld_rvalid}, 32'd0);
      step(); i_ld_addr = 32'h8; i_ld_wdata = 32'hCAFE_0008; #1;
      chk("w2_addr", o_mem_addr, 32'h8);
      chk("w2_cnt", {16'b0, o_ld_wr_count}, 32'd2);
      step(); i_ld_req = 0; #1;
      chk("w3_cnt", {16'b0, o_ld_wr_count}, 32'd3);
      chk("w3_if_blocked", {31'b0, o_if_gnt}, 32'd0);

      // Out-of-range write at 0x1000
      i_ld_req = 1; i_ld_addr = 32'h1000; #1;
      chk("oor_gnt", {31'b0, o_ld_gnt}, 32'd1);
      chk("oor_write", {31'b0, o_mem_write}, 32'd0);
      chk("oor_err_pre", {31'b0, o_ld_err}, 32'd0);
      step(); i_ld_req = 0; #1;
      chk("oor_err", {31'b0, o_ld_err}, 32'd1);
      chk("oor_cnt", {16'b0, o_ld_wr_count}, 32'd3);
      step();
      chk("oor_err_end", {31'b0, o_ld_err}, 32'd0);

      // Start and done together in LOAD: done wins
      i_ld_start = 1; i_ld_done = 1;
      step(); i_ld_start = 0; i_ld_done = 0; #1;
      chk("sd_hold", {31'b0, o_cpu_hold}, 32'd0);
      chk("sd_if_gnt", {31'b0, o_if_gnt}, 32'd1);
      chk("sd_cnt", {16'b0, o_ld_wr_count}, 32'd3);

      // Re-entering LOAD clears the write count
      i_ld_start = 1;
      step(); i_ld_start = 0; #1;
      chk("re_cnt_clr", {16'b0, o_ld_wr_count}, 32'd0);
      chk("re_hold", {31'b0, o_cpu_hold}, 32'd1);
      i_ld_done = 1;
      step(); i_ld_done = 0; #1;
      chk("done_hold", {31'b0, o_cpu_hold}, 32'd0);

      // Reset asserted before the granted fetch's rvalid edge
      chk("r_gnt", {31'b0, o_if_gnt}, 32'd1);
      #2; i_rst = 1; #1;
      chk("r_async_gnt", {31'b0, o_if_gnt}, 32'd0);
      chk("r_async_read", {31'b0, o_mem_read}, 32'd0);
      chk("r_async_rdata", o_if_rdata, 32'd0);
      chk("r_boot_hold", {31'b0, b_cpu_hold}, 32'd1);
      step(); i_if_req = 0; i_mem_rd_data = 32'h5555_5555; #1;
      chk("r_in_rvalid", {31'b0, o_if_rvalid}, 32'd0);
      i_rst = 0;
      step(); #1;
      chk("r_after_rvalid", {31'b0, o_if_rvalid}, 32'd0);
      chk("r_after_hold", {31'b0, o_cpu_hold}, 32'd0);
      chk("r_after_boot_hold", {31'b0, b_cpu_hold}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the core's instruction-fetch port and the program loader/debug port.
- Performs round-robin arbitration with at most one memory access per cycle.
- Routes 1-cycle-latency read data back to the requester that issued the read.
- Runs a RUN/LOAD mode FSM. In LOAD the core is held, fetch is blocked, and the loader owns the memory.

Parameters:
- MEM_ADDR_WIDTH, 12, byte-address bits decoded by the memory; loader writes outside this range are rejected.
- BOOT_IN_LOAD, 0, reset state of the mode FSM (1 = LOAD, 0 = RUN).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_if_req  in  1  fetch read request
- i_if_addr  in  32  fetch byte address
- o_if_gnt  out  1  fetch access issued this cycle
- o_if_rvalid  out  1  fetch read data valid
- o_if_rdata  out  32  fetch read data
- i_ld_req  in  1  loader request
- i_ld_we  in  1  loader write (1) / read (0)
- i_ld_addr  in  32  loader byte address
- i_ld_wdata  in  32  loader write data
- i_ld_size  in  4  loader byte enables
- o_ld_gnt  out  1  loader access issued this cycle
- o_ld_rvalid  out  1  loader read data valid
- o_ld_rdata  out  32  loader read data
- o_ld_err  out  1  pulse: out-of-range write dropped
- i_ld_start  in  1  pulse: enter LOAD
- i_ld_done  in  1  pulse: return to RUN
- o_cpu_hold  out  1  core stall while in LOAD
- o_ld_wr_count  out  16  count of completed loader writes since last LOAD entry
- o_mem_addr  out  32  to memory
- o_mem_wr_data  out  32  to memory
- o_mem_size  out  4  to memory
- o_mem_write  out  1  to memory
- o_mem_read  out  1  to memory
- i_mem_rd_data  in  32  from memory; valid 1 cycle after o_mem_read

Behaviour:

Reset (asynchronous on i_rst):
- Mode = LOAD if BOOT_IN_LOAD, else RUN.
- RR pointer = "loader last", so fetch wins the first tie.
- All registered outputs are 0: rvalids, rdata, o_ld_err, o_ld_wr_count.
- o_cpu_hold = BOOT_IN_LOAD.

Grant logic (combinational):
- Grants are combinational from req in the same cycle; at most one gnt per cycle.
- Fetch is eligible only in RUN.
- Loader is eligible in both modes.
- One eligible requester: it is granted.
- Both eligible: the requester not granted last wins. The pointer updates on every grant.

Memory drive:
- When a requester is granted, its address drives o_mem_addr.
- Reads: o_mem_read=1, o_mem_size=4'b1111.
- Loader writes: o_mem_write=1, o_mem_size=i_ld_size, o_mem_wr_data=i_ld_wdata.
- No grant: o_mem_read=o_mem_write=0; addr, data and size are 0.

Out-of-range loader writes:
- A loader write with any bit of i_ld_addr[31:MEM_ADDR_WIDTH] set is still granted (req is consumed).
- o_mem_write stays 0 and o_ld_err pulses for 1 cycle on the next edge.
- o_ld_wr_count does not increment.

Read return:
- The owner of an issued read is registered.
- Next cycle, the owner's rvalid=1 and its rdata is captured from i_mem_rd_data; the other requester's rvalid stays 0.
- rdata holds its value until the next rvalid for that requester.
- Writes produce no rvalid.

Write counter:
- o_ld_wr_count increments on each in-range loader write grant.
- It saturates at 16'hFFFF and clears on the RUN->LOAD transition.

Mode FSM:
- RUN->LOAD on i_ld_start. Takes effect on the next edge: fetch is blocked starting the cycle after the start pulse.
- A fetch read granted in the start cycle still returns its rvalid.
- LOAD->RUN on i_ld_done.
- i_ld_start and i_ld_done together: i_ld_done wins, state is RUN.
- o_cpu_hold = (state==LOAD), registered.

Reset mid-read:
- Pending rvalid is cancelled; no rvalid after reset deasserts.

Test Plan:
- Fetch only, RUN: i_if_req with addr 0x10 for 3 cycles -> o_if_gnt 3 cycles, o_mem_read=1 with addr 0x10; o_if_rvalid on cycles 2-4 returning i_mem_rd_data.
- Contention: both requesting reads for 4 cycles from reset -> grant order fetch, loader, fetch, loader; each rvalid is routed only to its owner 1 cycle later.
- Load sequence: i_ld_start pulse, then 3 loader writes to 0x0/0x4/0x8 with size 4'hF while i_if_req=1 -> o_cpu_hold=1, o_if_gnt=0, o_mem_write three times, o_ld_wr_count=3; after i_ld_done, o_cpu_hold=0 and fetch is granted.
- Out-of-range: MEM_ADDR_WIDTH=12, loader write to 0x1000 -> o_ld_gnt=1, o_mem_write=0, o_ld_err pulses once, count unchanged.
- Boundary: fetch granted in the same cycle as i_ld_start -> its o_if_rvalid still arrives next cycle; simultaneous i_ld_start and i_ld_done in LOAD -> state RUN.
- Reset: assert i_rst the cycle after a fetch grant -> o_if_rvalid stays 0 and all outputs are 0 asynchronously; with BOOT_IN_LOAD=1, o_cpu_hold=1 out of reset.
